// File: rtl/sumador_sched.sv
// sumador_sched: round-robin scheduler that lends the shared 8-bit adder to
// one of two requesters at a time, drives the adder enable for the requested
// burst length, and reports completion plus any carry-out seen in the burst.
module sumador_sched #(
    parameter int LEN_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             cout,
    output logic             enable,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             ovf,
    output logic             busy
);

    // Gap counter only needs to reach GAP-1; keep it at least one bit wide.
    localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_q, last_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               winner;
    logic [LEN_W-1:0]   winLen;

    // State and datapath registers; reset parks the scheduler in IDLE with
    // requester 1 marked as last so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            last_q    <= 1'b1;
            ovf_acc_q <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            ovf_acc_q <= ovf_acc_d;
            gap_q     <= gap_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count the burst down in RUN,
    // then pass through DONE and the optional GAP back to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        ovf_acc_d = ovf_acc_q;
        gap_d     = gap_q;
        winner    = 1'b0;
        winLen    = len0;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    if (req == 2'b01) begin
                        winner = 1'b0;
                    end else if (req == 2'b10) begin
                        winner = 1'b1;
                    end else begin
                        winner = ~last_q;
                    end
                    winLen    = winner ? len1 : len0;
                    last_d    = winner;
                    gnt_d     = winner ? 2'b10 : 2'b01;
                    cnt_d     = winLen;
                    ovf_acc_d = 1'b0;
                    state_d   = (winLen == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                cnt_d     = cnt_q - LEN_W'(1);
                ovf_acc_d = ovf_acc_q | cout;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ovf_acc_d = ovf_acc_q | cout;
                gap_d     = '0;
                state_d   = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register so reset drops them at once.
    always_comb begin
        enable = (state_q == S_RUN);
        gnt    = ((state_q == S_RUN) || (state_q == S_DONE)) ? gnt_q : 2'b00;
        done   = (state_q == S_DONE) ? gnt_q : 2'b00;
        ovf    = (state_q == S_DONE) && ovf_acc_q;
        busy   = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_sumador_sched.sv
// Directed testbench for sumador_sched: each task drives one scenario and
// compares the packed output vector {enable, gnt, done, ovf, busy} cycle by
// cycle against hand-derived expectations.
module tb_sumador_sched;

    localparam int LEN_W = 8;
    localparam int GAP_C = 2;

    localparam logic [6:0] RUN0  = 7'b1_01_00_0_1;
    localparam logic [6:0] RUN1  = 7'b1_10_00_0_1;
    localparam logic [6:0] GAPV  = 7'b0_00_00_0_1;
    localparam logic [6:0] IDLEV = 7'b0_00_00_0_0;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             cout;
    logic             enable;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             ovf;
    logic             busy;
    logic [6:0]       obs;

    int assertCount = 0;
    int failCount   = 0;

    sumador_sched #(.LEN_W(LEN_W), .GAP(GAP_C)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .len0   (len0),
        .len1   (len1),
        .cout   (cout),
        .enable (enable),
        .gnt    (gnt),
        .done   (done),
        .ovf    (ovf),
        .busy   (busy)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    assign obs = {enable, gnt, done, ovf, busy};

    // Advance to just after the next rising edge, where outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs in cycle i after the grant edge of a burst of length L
    // won by requester g: L RUN cycles, one DONE, GAP idle-busy cycles, IDLE.
    function automatic logic [6:0] expBurst(input logic g, input int L,
                                            input logic o, input int i);
        logic [1:0] oneHot;
        oneHot = g ? 2'b10 : 2'b01;
        if (i < L)               return g ? RUN1 : RUN0;
        else if (i == L)         return {1'b0, oneHot, oneHot, o, 1'b1};
        else if (i <= L + GAP_C) return GAPV;
        else                     return IDLEV;
    endfunction

    // Everything low while reset is held and after it is released.
    task automatic test_reset();
        rst  = 1'b1;
        req  = 2'b00;
        len0 = '0;
        len1 = '0;
        cout = 1'b0;
        #3;
        assertCount++;
        if (obs !== IDLEV) begin
            failCount++;
            $display("[TB] FAIL reset_async: got %b, expected %b", obs, IDLEV);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        assertCount++;
        if (obs !== IDLEV) begin
            failCount++;
            $display("[TB] FAIL reset_release: got %b, expected %b", obs, IDLEV);
        end
    endtask

    // Both requesting from reset: grants alternate 0,1,0,1 with lengths 3,4.
    task automatic test_tie();
        logic g;
        int   L;
        logic [6:0] expV;
        req  = 2'b11;
        len0 = 8'd3;
        len1 = 8'd4;
        for (int b = 0; b < 4; b++) begin
            g = b[0];
            L = g ? 4 : 3;
            for (int i = 0; i < L + 4; i++) begin
                tick();
                expV = expBurst(g, L, 1'b0, i);
                assertCount++;
                if (obs !== expV) begin
                    failCount++;
                    $display("[TB] FAIL tie burst %0d cycle %0d: got %b, expected %b",
                             b, i, obs, expV);
                end
            end
        end
        req = 2'b00;
        tick();
    endtask

    // Single requester 0 with length 5.
    task automatic test_single();
        logic [6:0] expV;
        req  = 2'b01;
        len0 = 8'd5;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) req = 2'b00;
            expV = expBurst(1'b0, 5, 1'b0, i);
            assertCount++;
            if (obs !== expV) begin
                failCount++;
                $display("[TB] FAIL single cycle %0d: got %b, expected %b", i, obs, expV);
            end
        end
    endtask

    // Zero length: DONE straight after the grant edge, no enable.
    task automatic test_zero_len();
        logic [6:0] expV;
        req  = 2'b10;
        len1 = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) req = 2'b00;
            expV = expBurst(1'b1, 0, 1'b0, i);
            assertCount++;
            if (obs !== expV) begin
                failCount++;
                $display("[TB] FAIL zero_len cycle %0d: got %b, expected %b", i, obs, expV);
            end
        end
    endtask

    // Maximum length with one cout pulse in RUN cycle 200, then a clean burst.
    task automatic test_overflow();
        logic [6:0] expV;
        int enCount;
        enCount = 0;
        req  = 2'b01;
        len0 = 8'd255;
        for (int i = 0; i < 259; i++) begin
            tick();
            if (i == 0)   req  = 2'b00;
            if (i == 199) cout = 1'b1;
            if (i == 200) cout = 1'b0;
            if (enable === 1'b1) enCount++;
            expV = expBurst(1'b0, 255, 1'b1, i);
            assertCount++;
            if (obs !== expV) begin
                failCount++;
                $display("[TB] FAIL overflow cycle %0d: got %b, expected %b", i, obs, expV);
            end
        end
        assertCount++;
        if (enCount !== 255) begin
            failCount++;
            $display("[TB] FAIL overflow_len: got %0d enable cycles, expected 255", enCount);
        end
        req  = 2'b01;
        len0 = 8'd3;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) req = 2'b00;
            expV = expBurst(1'b0, 3, 1'b0, i);
            assertCount++;
            if (obs !== expV) begin
                failCount++;
                $display("[TB] FAIL overflow_clear cycle %0d: got %b, expected %b",
                         i, obs, expV);
            end
        end
    endtask

    // Dropping req and shrinking len0 mid-burst must not shorten the burst.
    task automatic test_input_change();
        logic [6:0] expV;
        req  = 2'b01;
        len0 = 8'd10;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 2) begin
                req  = 2'b00;
                len0 = 8'd2;
            end
            expV = expBurst(1'b0, 10, 1'b0, i);
            assertCount++;
            if (obs !== expV) begin
                failCount++;
                $display("[TB] FAIL input_change cycle %0d: got %b, expected %b",
                         i, obs, expV);
            end
        end
    endtask

    // Reset between edges in RUN cycle 4, then a tie must go to requester 0.
    task automatic test_async_reset();
        logic [6:0] expV;
        req  = 2'b10;
        len1 = 8'd10;
        for (int i = 0; i < 4; i++) begin
            tick();
            expV = RUN1;
            assertCount++;
            if (obs !== expV) begin
                failCount++;
                $display("[TB] FAIL async_pre cycle %0d: got %b, expected %b", i, obs, expV);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        assertCount++;
        if (obs !== IDLEV) begin
            failCount++;
            $display("[TB] FAIL async_drop: got %b, expected %b", obs, IDLEV);
        end
        tick();
        tick();
        assertCount++;
        if (obs !== IDLEV) begin
            failCount++;
            $display("[TB] FAIL async_hold: got %b, expected %b", obs, IDLEV);
        end
        rst  = 1'b0;
        req  = 2'b11;
        len0 = 8'd3;
        len1 = 8'd4;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) req = 2'b00;
            expV = expBurst(1'b0, 3, 1'b0, i);
            assertCount++;
            if (obs !== expV) begin
                failCount++;
                $display("[TB] FAIL async_after cycle %0d: got %b, expected %b",
                         i, obs, expV);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting sumador_sched directed tests");
        test_reset();
        test_tie();
        test_single();
        test_zero_len();
        test_overflow();
        test_input_change();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
